reg_op_sequencer: RTL and testbench
===================================

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter N, default 8, SHALL set the data width of operands, immediate, result and register-file data.
REQ-002 Parameter A, default 3, SHALL set the register-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  SHALL indicate a command is present.
REQ-006 cmd_ready  out  1  SHALL indicate the block accepts a command this cycle.
REQ-007 cmd_op  in  3  SHALL carry the opcode.
REQ-008 cmd_rd, cmd_rs1, cmd_rs2  in  A each  SHALL carry the destination and source register addresses.
REQ-009 cmd_imm  in  N  SHALL carry the immediate for LDI.
REQ-010 ra1, ra2  out  A each  SHALL drive the register-file read addresses.
REQ-011 rd1, rd2  in  N each  SHALL be the register-file read data (combinational read).
REQ-012 wa3  out  A, wd3  out  N, we3  out  1  SHALL drive the register-file write port (written on rising clk while we3=1).
REQ-013 done  out  1, result  out  N, zero  out  1, carry  out  1  SHALL report completion, result value and flags.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, EXEC and WRITE, and cmd_ready SHALL be 1 only in IDLE.
REQ-015 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; op, rd, rs1, rs2 and imm are latched at that edge and the FSM moves IDLE->READ.
REQ-016 Command inputs SHALL be ignored in every non-IDLE state.
REQ-017 ra1/ra2 SHALL equal the latched rs1/rs2 from READ onward; at the end of READ, rd1/rd2 are captured into operand registers op1/op2, and the FSM moves READ->EXEC.
REQ-018 In EXEC the result and flags SHALL be computed from op1/op2/imm and registered, and the FSM moves EXEC->WRITE.
REQ-019 Opcodes SHALL be: 000 ADD op1+op2; 001 SUB op1-op2; 010 AND; 011 OR; 100 XOR; 101 LDI result=imm; 110 SHL op1<<1; 111 CMP, computed as SUB with no write-back.
REQ-020 Arithmetic SHALL be modulo 2^N; the ADD carry is bit N of the (N+1)-bit sum; the SUB/CMP carry is the unsigned borrow (op1<op2); the SHL carry is op1[N-1]; AND/OR/XOR/LDI SHALL clear carry.
REQ-021 zero SHALL be 1 exactly when the N-bit result equals 0.
REQ-022 In WRITE, done SHALL be 1 for exactly one cycle, with wa3=latched rd and wd3=result; we3=1 for that cycle except for CMP, where we3=0. The FSM then moves WRITE->IDLE.
REQ-023 Latency: for a command accepted at edge T, the write occurs at edge T+3, and cmd_ready SHALL return to 1 in the cycle after WRITE, giving a maximum throughput of one command per 4 cycles.
REQ-024 When rd equals rs1 or rs2, the operands SHALL be the pre-write values.
REQ-025 result, zero and carry SHALL hold their values until the next EXEC.
REQ-026 we3 and done SHALL be 0 in IDLE, READ and EXEC.

Reset
REQ-027 On rst=0 the block SHALL asynchronously enter IDLE with cmd_ready=1, we3=0, done=0, result=0, zero=0, carry=0, ra1=ra2=wa3=0 and wd3=0.
REQ-028 A reset asserted during READ, EXEC or WRITE SHALL abort the command without a write; we3 SHALL drop immediately and no done pulse SHALL be produced.
REQ-029 While rst=0, cmd_valid SHALL be ignored.

Verification
REQ-030 LDI rd=1 imm=8'hAB -> we3=1, wa3=1, wd3=8'hAB, done=1 three edges after acceptance; zero=0, carry=0.
REQ-031 LDI r2=8'hF0, LDI r3=8'h20, then ADD rd=4 rs1=2 rs2=3 -> wd3=8'h10, carry=1, zero=0.
REQ-032 With r2=8'h20 and r3=8'hF0: CMP rs1=2 rs2=3 -> we3 stays 0, done=1, carry=1; SUB rd=5 rs1=3 rs2=3 -> wd3=0, zero=1, carry=0.
REQ-033 cmd_valid held at 1 with back-to-back commands -> cmd_ready=1 only every 4th cycle, and each command is accepted exactly once.
REQ-034 rst driven to 0 during EXEC of ADD rd=6 -> we3 never asserts and r6 is unchanged; after release cmd_ready=1 and the next LDI completes normally.
REQ-035 SHL rd=1 rs1=1 with r1=8'h81 -> wd3=8'h02, carry=1; then XOR rd=1 rs1=1 rs2=1 -> wd3=0, zero=1.

Source files
------------

// File: rtl/reg_op_sequencer_if.sv
// Command channel of the register-operation sequencer.
// A valid/ready handshake that carries the opcode, the three register
// addresses and the immediate.
interface reg_op_sequencer_if #(
    parameter int N = 8,
    parameter int A = 3
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [A-1:0] cmd_rd;
    logic [A-1:0] cmd_rs1;
    logic [A-1:0] cmd_rs2;
    logic [N-1:0] cmd_imm;

    // The command issuer drives the command and watches cmd_ready.
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rd,
        output cmd_rs1,
        output cmd_rs2,
        output cmd_imm,
        input  cmd_ready
    );

    // The sequencer consumes the command and advertises readiness.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rd,
        input  cmd_rs1,
        input  cmd_rs2,
        input  cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/reg_op_sequencer.sv
// Register-operation sequencer.
// Takes one command at a time and walks it through four states:
// IDLE (accept) -> READ (address the register file) -> EXEC (ALU) ->
// WRITE (write back and pulse done). The register file lives outside
// and is read combinationally. Every output comes straight from a
// register, so nothing combinational reaches a port.
module reg_op_sequencer #(
    parameter int N = 8,
    parameter int A = 3
) (
    input  logic                clk,
    input  logic                rst,
    reg_op_sequencer_if.slave   cmd,
    output logic [A-1:0]        ra1,
    output logic [A-1:0]        ra2,
    input  logic [N-1:0]        rd1,
    input  logic [N-1:0]        rd2,
    output logic [A-1:0]        wa3,
    output logic [N-1:0]        wd3,
    output logic                we3,
    output logic                done,
    output logic [N-1:0]        result,
    output logic                zero,
    output logic                carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t       state_reg;
    logic         ready_reg;

    // Fields latched when a command is accepted
    logic [2:0]   op_reg;
    logic [A-1:0] rd_reg;
    logic [A-1:0] rs1_reg;
    logic [A-1:0] rs2_reg;
    logic [N-1:0] imm_reg;

    // Operands captured at the end of READ. They hold the values from
    // before the write, even when rd names one of the sources.
    logic [N-1:0] op1_reg;
    logic [N-1:0] op2_reg;

    // Result, flags and write-port state
    logic [N-1:0] result_reg;
    logic         zero_reg;
    logic         carry_reg;
    logic [N-1:0] wd3_reg;
    logic         we3_reg;
    logic         done_reg;

    // ALU outputs, sampled only in EXEC
    logic [N:0]   sum_ext;
    logic [N:0]   diff_ext;
    logic [N-1:0] alu_result_next;
    logic         alu_carry_next;
    logic         alu_zero_next;

    // Extended add and subtract. Bit N of the difference is the
    // unsigned borrow, which is set exactly when op1 < op2.
    assign sum_ext  = {1'b0, op1_reg} + {1'b0, op2_reg};
    assign diff_ext = {1'b0, op1_reg} - {1'b0, op2_reg};

    // Combinational ALU: choose result and carry by the latched opcode
    always_comb begin
        alu_result_next = '0;
        alu_carry_next  = 1'b0;
        unique case (op_reg)
            OP_ADD: begin
                alu_result_next = sum_ext[N-1:0];
                alu_carry_next  = sum_ext[N];
            end
            OP_SUB, OP_CMP: begin
                alu_result_next = diff_ext[N-1:0];
                alu_carry_next  = diff_ext[N];
            end
            OP_AND: alu_result_next = op1_reg & op2_reg;
            OP_OR:  alu_result_next = op1_reg | op2_reg;
            OP_XOR: alu_result_next = op1_reg ^ op2_reg;
            OP_LDI: alu_result_next = imm_reg;
            OP_SHL: begin
                alu_result_next = {op1_reg[N-2:0], 1'b0};
                alu_carry_next  = op1_reg[N-1];
            end
            default: begin
                alu_result_next = '0;
                alu_carry_next  = 1'b0;
            end
        endcase
        alu_zero_next = (alu_result_next == '0);
    end

    // Sequencer FSM and all registered outputs. Reset aborts any
    // command in flight, and we3/done fall at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            ready_reg  <= 1'b1;
            op_reg     <= '0;
            rd_reg     <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            imm_reg    <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            wd3_reg    <= '0;
            we3_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (cmd.cmd_valid && ready_reg) begin
                        op_reg    <= cmd.cmd_op;
                        rd_reg    <= cmd.cmd_rd;
                        rs1_reg   <= cmd.cmd_rs1;
                        rs2_reg   <= cmd.cmd_rs2;
                        imm_reg   <= cmd.cmd_imm;
                        ready_reg <= 1'b0;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    op1_reg   <= rd1;
                    op2_reg   <= rd2;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    result_reg <= alu_result_next;
                    zero_reg   <= alu_zero_next;
                    carry_reg  <= alu_carry_next;
                    wd3_reg    <= alu_result_next;
                    we3_reg    <= (op_reg != OP_CMP);
                    done_reg   <= 1'b1;
                    state_reg  <= WRITE;
                end
                WRITE: begin
                    we3_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    we3_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = ready_reg;
    assign ra1           = rs1_reg;
    assign ra2           = rs2_reg;
    assign wa3           = rd_reg;
    assign wd3           = wd3_reg;
    assign we3           = we3_reg;
    assign done          = done_reg;
    assign result        = result_reg;
    assign zero          = zero_reg;
    assign carry         = carry_reg;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Testbench for reg_op_sequencer.
// Contains an external register file and a reference model written
// directly from the opcode rules. It runs the directed vectors, then
// random back-to-back commands with cmd_valid held high, then a reset
// that aborts a command during EXEC.
module tb_reg_op_sequencer;
    localparam int N    = 8;
    localparam int A    = 3;
    localparam int MASK = (1 << N) - 1;
    localparam int NREG = 1 << A;

    localparam int ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, LDI = 5, SHL = 6, CMP = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [A-1:0] ra1, ra2, wa3;
    logic [N-1:0] rd1, rd2, wd3, result;
    logic         we3, done, zero, carry;

    reg_op_sequencer_if #(.N(N), .A(A)) cmd_if ();

    reg_op_sequencer #(.N(N), .A(A)) dut (
        .clk    (clk),
        .rst    (rst),
        .cmd    (cmd_if),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .wa3    (wa3),
        .wd3    (wd3),
        .we3    (we3),
        .done   (done),
        .result (result),
        .zero   (zero),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    // External register file: combinational read, write on the clock edge
    logic [N-1:0] rf [NREG];
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];
    always @(posedge clk) if (we3 === 1'b1) rf[wa3] <= wd3;

    // Reference register contents, changed only by the model
    logic [N-1:0] ref_rf [NREG];

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int wr_count   = 0;
    int exp_writes = 0;
    int last_acc   = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (we3 === 1'b1) wr_count <= wr_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue one command starting at a negedge and check every phase
    // until the negedge after WRITE.
    task automatic run_cmd(input int op, input int rd, input int rs1, input int rs2,
                           input int imm, input bit hold_valid, input bit chk_spacing);
        int a, b, s, res, c, z, waits, acc;
        cmd_if.cmd_op    = 3'(op);
        cmd_if.cmd_rd    = A'(rd);
        cmd_if.cmd_rs1   = A'(rs1);
        cmd_if.cmd_rs2   = A'(rs2);
        cmd_if.cmd_imm   = N'(imm);
        cmd_if.cmd_valid = 1'b1;
        waits = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        check("accept_wait", 32'(cmd_if.cmd_ready), 32'd1);
        if (cmd_if.cmd_ready !== 1'b1) begin
            cmd_if.cmd_valid = 1'b0;
            return;
        end

        // Reference model built from the opcode rules, using the
        // register values from before the write
        a = int'(ref_rf[rs1]);
        b = int'(ref_rf[rs2]);
        c = 0;
        case (op)
            ADD:      begin s = a + b; res = s & MASK; c = (s > MASK) ? 1 : 0; end
            SUB, CMP: begin res = (a - b) & MASK; c = (a < b) ? 1 : 0; end
            AND_:     res = a & b;
            OR_:      res = a | b;
            XOR_:     res = a ^ b;
            LDI:      res = imm & MASK;
            default:  begin s = a * 2; res = s & MASK; c = (s > MASK) ? 1 : 0; end
        endcase
        z = (res == 0) ? 1 : 0;

        @(posedge clk);
        #1;
        acc = cyc;
        if (chk_spacing) check("accept_spacing", 32'(acc - last_acc), 32'd4);
        last_acc = acc;
        if (hold_valid) begin
            // Send junk while busy: the sequencer must not take it
            cmd_if.cmd_op  = 3'($urandom);
            cmd_if.cmd_rd  = A'($urandom);
            cmd_if.cmd_rs1 = A'($urandom);
            cmd_if.cmd_rs2 = A'($urandom);
            cmd_if.cmd_imm = N'($urandom);
        end else begin
            cmd_if.cmd_valid = 1'b0;
        end

        @(negedge clk);   // READ
        check("read_ra1", 32'(ra1), 32'(rs1));
        check("read_ra2", 32'(ra2), 32'(rs2));
        check("read_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check("read_we3", 32'(we3), 32'd0);
        check("read_done", 32'(done), 32'd0);

        @(negedge clk);   // EXEC
        check("exec_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check("exec_we3", 32'(we3), 32'd0);
        check("exec_done", 32'(done), 32'd0);

        @(negedge clk);   // WRITE
        check("write_done", 32'(done), 32'd1);
        check("write_we3", 32'(we3), (op == CMP) ? 32'd0 : 32'd1);
        check("write_wa3", 32'(wa3), 32'(rd));
        check("write_wd3", 32'(wd3), 32'(res));
        check("write_result", 32'(result), 32'(res));
        check("write_zero", 32'(zero), 32'(z));
        check("write_carry", 32'(carry), 32'(c));
        check("write_ready", 32'(cmd_if.cmd_ready), 32'd0);
        if (op != CMP) begin
            ref_rf[rd] = N'(res);
            exp_writes++;
        end

        @(negedge clk);   // back in IDLE
        check("idle_done", 32'(done), 32'd0);
        check("idle_we3", 32'(we3), 32'd0);
        check("idle_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("idle_result_hold", 32'(result), 32'(res));
        check("idle_rf", 32'(rf[rd]), 32'(ref_rf[rd]));
        $display("txn op=%0d rd=%0d rs1=%0d rs2=%0d imm=%02h a=%02h b=%02h res=%02h z=%0d c=%0d",
                 op, rd, rs1, rs2, imm, a, b, res, z, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_before;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_rd    = '0;
        cmd_if.cmd_rs1   = '0;
        cmd_if.cmd_rs2   = '0;
        cmd_if.cmd_imm   = '0;
        for (int i = 0; i < NREG; i++) begin
            rf[i]     = N'($urandom);
            ref_rf[i] = rf[i];
        end

        // Reset state, with cmd_valid asserted to show it is ignored
        #12;
        cmd_if.cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("rst_we3", 32'(we3), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_ra1", 32'(ra1), 32'd0);
        check("rst_ra2", 32'(ra2), 32'd0);
        check("rst_wa3", 32'(wa3), 32'd0);
        check("rst_wd3", 32'(wd3), 32'd0);
        cmd_if.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_cmd(LDI, 1, 0, 0, 8'hAB, 1'b0, 1'b0);
        check("ldi_r1", 32'(rf[1]), 32'h0AB);
        run_cmd(LDI, 2, 0, 0, 8'hF0, 1'b0, 1'b0);
        run_cmd(LDI, 3, 0, 0, 8'h20, 1'b0, 1'b0);
        run_cmd(ADD, 4, 2, 3, 0, 1'b0, 1'b0);
        check("add_r4", 32'(rf[4]), 32'h010);
        check("add_carry", 32'(carry), 32'd1);
        run_cmd(LDI, 2, 0, 0, 8'h20, 1'b0, 1'b0);
        run_cmd(LDI, 3, 0, 0, 8'hF0, 1'b0, 1'b0);
        run_cmd(CMP, 7, 2, 3, 0, 1'b0, 1'b0);
        check("cmp_carry", 32'(carry), 32'd1);
        run_cmd(SUB, 5, 3, 3, 0, 1'b0, 1'b0);
        check("sub_zero", 32'(zero), 32'd1);
        run_cmd(LDI, 1, 0, 0, 8'h81, 1'b0, 1'b0);
        run_cmd(SHL, 1, 1, 0, 0, 1'b0, 1'b0);
        check("shl_r1", 32'(rf[1]), 32'h002);
        check("shl_carry", 32'(carry), 32'd1);
        run_cmd(XOR_, 1, 1, 1, 0, 1'b0, 1'b0);
        check("xor_zero", 32'(zero), 32'd1);

        // Random back-to-back commands with cmd_valid held high
        for (int i = 0; i < 40; i++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, NREG - 1)),
                    int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                    int'($urandom_range(0, MASK)), 1'b1, (i > 0));
        end
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);

        // Reset during EXEC of ADD rd=6 aborts it
        run_cmd(LDI, 6, 0, 0, 8'h5A, 1'b0, 1'b0);
        wr_before = wr_count;
        cmd_if.cmd_op    = 3'(ADD);
        cmd_if.cmd_rd    = 3'd6;
        cmd_if.cmd_rs1   = 3'd2;
        cmd_if.cmd_rs2   = 3'd3;
        cmd_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk);   // now in EXEC
        #2;
        rst = 1'b0;
        #1;
        check("abort_we3", 32'(we3), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        cmd_if.cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_hold_we3", 32'(we3), 32'd0);
        check("abort_hold_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_r6", 32'(rf[6]), 32'h05A);
        check("abort_no_write", 32'(wr_count), 32'(wr_before));
        check("abort_ready_after", 32'(cmd_if.cmd_ready), 32'd1);
        run_cmd(LDI, 6, 0, 0, 8'h3C, 1'b0, 1'b0);
        check("post_abort_r6", 32'(rf[6]), 32'h03C);

        check("write_count", 32'(wr_count), 32'(exp_writes));
        for (int i = 0; i < NREG; i++) check("final_rf", 32'(rf[i]), 32'(ref_rf[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
